// File: rtl/bsg_manycore_drlp_slave_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bsg_manycore_drlp_pkg
//  Brief   : Shared types and constants for the DRLP slave sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
package bsg_manycore_drlp_pkg;

  // Tile-facing widths; the sequencer parameters default to these values.
  localparam int DRLP_IMEM_ADDR_WIDTH = 13;
  localparam int DRLP_LEN_WIDTH       = 13;
  localparam int DRLP_NUM_PE          = 16;
  localparam int DRLP_WGT_CYC_WIDTH   = 8;

  // Sequencer phases for one compute pass.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WGT       = 3'd1,
    WAIT_RDY  = 3'd2,
    STREAM    = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5
  } drlp_seq_state_e;

  // One job as latched from the host command interface.
  typedef struct packed {
    logic [DRLP_IMEM_ADDR_WIDTH-1:0] base;
    logic [DRLP_LEN_WIDTH-1:0]       len;
    logic [DRLP_NUM_PE-1:0]          mask;
    logic [DRLP_WGT_CYC_WIDTH-1:0]   wgt_cycles;
  } drlp_job_s;

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_drlp_slave_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module  : bsg_manycore_drlp_slave_sequencer_if
//  Brief   : Host command handshake plus DRLP tile drive/observe signals.
//  Revision: 1.0 - initial release
// ============================================================================
interface bsg_manycore_drlp_slave_sequencer_if #(
  parameter int imem_addr_width_p = 13,
  parameter int num_pe_p          = 16,
  parameter int len_width_p       = 13,
  parameter int wgt_cyc_width_p   = 8
);

  logic                         cmd_v_i;
  logic                         cmd_ready_o;
  logic [imem_addr_width_p-1:0] cmd_imem_base_i;
  logic [len_width_p-1:0]       cmd_len_i;
  logic [num_pe_p-1:0]          cmd_pe_mask_i;
  logic [wgt_cyc_width_p-1:0]   cmd_wgt_cycles_i;

  logic [num_pe_p-1:0]          pe_data_v_o;
  logic                         sld_o;
  logic [imem_addr_width_p-1:0] imem_r_addr_o;
  logic                         dw_wgt_start_o;
  logic                         all_pe_ready_i;
  logic                         all_slave_done_i;

  logic                         busy_o;
  logic                         done_o;
  logic                         error_o;

  // Sequencer side.
  modport slave (
    input  cmd_v_i, cmd_imem_base_i, cmd_len_i, cmd_pe_mask_i, cmd_wgt_cycles_i,
    input  all_pe_ready_i, all_slave_done_i,
    output cmd_ready_o, pe_data_v_o, sld_o, imem_r_addr_o, dw_wgt_start_o,
    output busy_o, done_o, error_o
  );

  // Host / tile side.
  modport master (
    output cmd_v_i, cmd_imem_base_i, cmd_len_i, cmd_pe_mask_i, cmd_wgt_cycles_i,
    output all_pe_ready_i, all_slave_done_i,
    input  cmd_ready_o, pe_data_v_o, sld_o, imem_r_addr_o, dw_wgt_start_o,
    input  busy_o, done_o, error_o
  );

endinterface
`default_nettype wire

// File: rtl/bsg_manycore_drlp_slave_sequencer_timeout.sv
`default_nettype none
// ============================================================================
//  Module  : bsg_drlp_seq_timeout
//  Brief   : Loadable saturating up-counter with clear and terminal-count flag.
//            tc_o rises when the count equals timeout_p-1, i.e. on the
//            timeout_p-th counted cycle since the last clear.
//  Revision: 1.0 - initial release
// ============================================================================
module bsg_drlp_seq_timeout #(
  parameter int timeout_p = 4096,
  parameter int width_p   = $clog2(timeout_p + 1)
) (
  input  wire logic               clk_i,
  input  wire logic               reset_i,
  input  wire logic               clear_i,
  input  wire logic               load_i,
  input  wire logic [width_p-1:0] load_val_i,
  input  wire logic               en_i,
  output logic                    tc_o
);

  logic [width_p-1:0] r_cnt;

  // Count wait cycles; clear wins over load, load wins over increment.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (en_i && !tc_o) begin
      r_cnt <= r_cnt + width_p'(1);
    end
  end

  assign tc_o = (r_cnt == width_p'(timeout_p - 1));

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_drlp_slave_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : bsg_manycore_drlp_slave_sequencer
//  Brief   : Sequences one DRLP slave pass: weight load, imem streaming,
//            completion wait. All outputs are registered and track the state
//            register, so tile inputs change on the cycle the state changes.
//  Revision: 1.0 - initial release
// ============================================================================
module bsg_manycore_drlp_slave_sequencer
  import bsg_manycore_drlp_pkg::*;
#(
  parameter int imem_addr_width_p = DRLP_IMEM_ADDR_WIDTH,
  parameter int num_pe_p          = DRLP_NUM_PE,
  parameter int len_width_p       = DRLP_LEN_WIDTH,
  parameter int wgt_cyc_width_p   = DRLP_WGT_CYC_WIDTH,
  parameter int timeout_p         = 4096
) (
  input  wire logic clk_i,
  input  wire logic reset_i,
  bsg_manycore_drlp_slave_sequencer_if.slave bus_if
);

  drlp_seq_state_e r_state, w_state_n;
  drlp_job_s       r_job, w_job_n;

  logic [len_width_p-1:0]       r_beat, w_beat_n;
  logic [wgt_cyc_width_p-1:0]   r_wgt_cnt, w_wgt_cnt_n;

  logic [num_pe_p-1:0]          r_pe_data_v, w_pe_data_v_n;
  logic                         r_sld, w_sld_n;
  logic [imem_addr_width_p-1:0] r_addr, w_addr_n;
  logic                         r_wgt_start, w_wgt_start_n;
  logic                         r_busy, w_busy_n;
  logic                         r_done, w_done_n;
  logic                         r_error, w_error_n;
  logic                         r_cmd_ready, w_cmd_ready_n;

  logic w_to_clear, w_to_en, w_to_tc, w_timeout;

  localparam int c_to_width = $clog2(timeout_p + 1);

  bsg_drlp_seq_timeout #(
    .timeout_p (timeout_p),
    .width_p   (c_to_width)
  ) u_timeout (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (w_to_clear),
    .load_i     (1'b0),
    .load_val_i ({c_to_width{1'b0}}),
    .en_i       (w_to_en),
    .tc_o       (w_to_tc)
  );

  // Next state, next registered outputs and timeout-counter control.
  always_comb begin
    w_state_n      = r_state;
    w_job_n        = r_job;
    w_beat_n       = r_beat;
    w_wgt_cnt_n    = r_wgt_cnt;
    w_pe_data_v_n  = '0;
    w_sld_n        = 1'b0;
    w_addr_n       = r_addr;
    w_wgt_start_n  = 1'b0;
    w_done_n       = 1'b0;
    w_error_n      = r_error;
    w_to_clear     = 1'b0;
    w_to_en        = 1'b0;
    w_timeout      = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus_if.cmd_v_i) begin
          w_job_n.base       = bus_if.cmd_imem_base_i;
          w_job_n.len        = bus_if.cmd_len_i;
          w_job_n.mask       = bus_if.cmd_pe_mask_i;
          w_job_n.wgt_cycles = bus_if.cmd_wgt_cycles_i;
          w_error_n          = 1'b0;
          w_beat_n           = '0;
          if (bus_if.cmd_wgt_cycles_i != '0) begin
            w_state_n     = WGT;
            w_sld_n       = 1'b1;
            w_wgt_start_n = 1'b1;
            w_wgt_cnt_n   = wgt_cyc_width_p'(1);
          end else begin
            w_state_n  = WAIT_RDY;
            w_to_clear = 1'b1;
          end
        end
      end

      // r_wgt_cnt is the index of the current sld cycle, starting at 1.
      WGT: begin
        if (r_wgt_cnt == r_job.wgt_cycles) begin
          w_state_n  = WAIT_RDY;
          w_to_clear = 1'b1;
        end else begin
          w_wgt_cnt_n = r_wgt_cnt + wgt_cyc_width_p'(1);
          w_sld_n     = 1'b1;
        end
      end

      WAIT_RDY: begin
        if (bus_if.all_pe_ready_i) begin
          w_state_n  = (r_job.len != '0) ? STREAM : WAIT_DONE;
          w_to_clear = 1'b1;
        end else if (w_to_tc) begin
          w_timeout = 1'b1;
        end else begin
          w_to_en = 1'b1;
        end
      end

      // A ready cycle issues one beat and restarts the stall window.
      STREAM: begin
        if (bus_if.all_pe_ready_i) begin
          w_pe_data_v_n = r_job.mask;
          w_addr_n      = r_job.base + imem_addr_width_p'(r_beat);
          w_beat_n      = r_beat + len_width_p'(1);
          w_to_clear    = 1'b1;
          if (r_beat == r_job.len - len_width_p'(1)) begin
            w_state_n = WAIT_DONE;
          end
        end else if (w_to_tc) begin
          w_timeout = 1'b1;
        end else begin
          w_to_en = 1'b1;
        end
      end

      WAIT_DONE: begin
        if (bus_if.all_slave_done_i) begin
          w_state_n = DONE;
          w_done_n  = 1'b1;
        end else if (w_to_tc) begin
          w_timeout = 1'b1;
        end else begin
          w_to_en = 1'b1;
        end
      end

      DONE: begin
        w_state_n = IDLE;
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase

    // Timeout abandons the job with every tile drive forced low.
    if (w_timeout) begin
      w_state_n = IDLE;
      w_error_n = 1'b1;
      w_addr_n  = '0;
    end

    w_busy_n      = (w_state_n != IDLE);
    w_cmd_ready_n = (w_state_n == IDLE);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Job, progress counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_job       <= '0;
      r_beat      <= '0;
      r_wgt_cnt   <= '0;
      r_pe_data_v <= '0;
      r_sld       <= 1'b0;
      r_addr      <= '0;
      r_wgt_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_job       <= w_job_n;
      r_beat      <= w_beat_n;
      r_wgt_cnt   <= w_wgt_cnt_n;
      r_pe_data_v <= w_pe_data_v_n;
      r_sld       <= w_sld_n;
      r_addr      <= w_addr_n;
      r_wgt_start <= w_wgt_start_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_error     <= w_error_n;
      r_cmd_ready <= w_cmd_ready_n;
    end
  end

  assign bus_if.cmd_ready_o    = r_cmd_ready;
  assign bus_if.pe_data_v_o    = r_pe_data_v;
  assign bus_if.sld_o          = r_sld;
  assign bus_if.imem_r_addr_o  = r_addr;
  assign bus_if.dw_wgt_start_o = r_wgt_start;
  assign bus_if.busy_o         = r_busy;
  assign bus_if.done_o         = r_done;
  assign bus_if.error_o        = r_error;

endmodule
`default_nettype wire
